// File: rtl/hack_fetch_sequencer.sv
// Fetch/execute sequencer for the Hack CPU: fetches each instruction over a ROM
// req/ack handshake, strobes execution once, and resolves the jump into PC load/inc.
module hack_fetch_sequencer #(
  parameter int WIDTH       = 16,
  parameter bit HALT_DETECT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  output logic             rom_req,
  input  logic             rom_ack,
  input  logic [WIDTH-1:0] instr,
  input  logic             alu_zr,
  input  logic             alu_ng,
  input  logic [WIDTH-1:0] a_reg,
  input  logic [WIDTH-1:0] pc_value,
  output logic             pc_reset,
  output logic             pc_load,
  output logic             pc_inc,
  output logic [WIDTH-1:0] ir,
  output logic             exec_en,
  output logic             busy,
  output logic             halted
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ir_q;
  logic             step_prev;

  logic             step_rise;
  logic             is_c_instr;
  logic [2:0]       jump_bits;
  logic             jump;
  logic             halt_hit;

  assign step_rise  = step & ~step_prev;
  assign is_c_instr = ir_q[WIDTH-1];
  assign jump_bits  = ir_q[2:0];

  // Hack jump field: j1 = less than zero, j2 = equal to zero, j3 = greater than zero.
  assign jump = is_c_instr & ((jump_bits[2] & alu_ng) |
                              (jump_bits[1] & alu_zr) |
                              (jump_bits[0] & ~alu_ng & ~alu_zr));

  // An unconditional jump whose target is its own address can never make progress.
  assign halt_hit = HALT_DETECT && is_c_instr && (jump_bits == 3'b111) &&
                    (a_reg == pc_value);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_INIT;
      ir_q      <= '0;
      step_prev <= 1'b0;
    end else begin
      step_prev <= step;
      case (state)
        S_INIT:  state <= S_IDLE;
        S_IDLE:  if (run || step_rise) state <= S_FETCH;
        S_FETCH: begin
          if (rom_ack) begin
            ir_q  <= instr;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (halt_hit)  state <= S_HALT;
          else if (run)  state <= S_FETCH;
          else           state <= S_IDLE;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_INIT;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rom_req  = 1'b0;
    pc_reset = 1'b0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    exec_en  = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    if (!reset) begin
      case (state)
        S_INIT:  pc_reset = 1'b1;
        S_FETCH: begin
          rom_req = 1'b1;
          busy    = 1'b1;
        end
        S_EXEC: begin
          exec_en = 1'b1;
          busy    = 1'b1;
          pc_load = jump;
          pc_inc  = ~jump;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign ir = reset ? '0 : ir_q;

endmodule

// File: tb/tb_hack_fetch_sequencer.sv
// Self-checking bench for hack_fetch_sequencer: directed scenarios plus a randomized
// instruction stream checked against a per-instruction reference model.
module tb_hack_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, step, rom_ack, alu_zr, alu_ng;
  logic [15:0] instr, a_reg, pc_value;
  logic        rom_req, pc_reset, pc_load, pc_inc, exec_en, busy, halted;
  logic [15:0] ir;

  int n_tests = 0;
  int n_fail  = 0;

  // Control vector order: {rom_req, pc_reset, pc_load, pc_inc, exec_en, busy, halted}
  localparam logic [6:0] EXP_IDLE  = 7'b0000000;
  localparam logic [6:0] EXP_INIT  = 7'b0100000;
  localparam logic [6:0] EXP_FETCH = 7'b1000010;
  localparam logic [6:0] EXP_HALT  = 7'b0000001;

  hack_fetch_sequencer #(.WIDTH(16), .HALT_DETECT(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .step     (step),
    .rom_req  (rom_req),
    .rom_ack  (rom_ack),
    .instr    (instr),
    .alu_zr   (alu_zr),
    .alu_ng   (alu_ng),
    .a_reg    (a_reg),
    .pc_value (pc_value),
    .pc_reset (pc_reset),
    .pc_load  (pc_load),
    .pc_inc   (pc_inc),
    .ir       (ir),
    .exec_en  (exec_en),
    .busy     (busy),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ctl();
    return {rom_req, pc_reset, pc_load, pc_inc, exec_en, busy, halted};
  endfunction

  // Reference: classify the ALU result as less/equal/greater and jump if the
  // instruction's jump mask selects that class. A-instructions never jump.
  function automatic logic ref_jump(input logic [15:0] i, input logic zr, input logic ng);
    logic [2:0] cls;
    cls = {ng, zr, (!ng && !zr)};
    return i[15] && ((i[2:0] & cls) != 3'b000);
  endfunction

  function automatic logic ref_halt(input logic [15:0] i, input logic [15:0] a, input logic [15:0] pc);
    return i[15] && (i[2:0] == 3'b111) && (a == pc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered 1 time unit after the edge that put the DUT in FETCH; returns in EXEC.
  task automatic do_instr(input logic [15:0] i, input int waits, input logic zr,
                          input logic ng, input logic [15:0] a, input logic [15:0] pc,
                          input logic step_exec, input string tag);
    logic [6:0] exp_v;
    logic       j;
    instr    = i;
    a_reg    = a;
    pc_value = pc;
    for (int k = 0; k <= waits; k++) begin
      rom_ack = (k == waits);
      alu_zr  = 1'($urandom);
      alu_ng  = 1'($urandom);
      #1;
      n_tests++;
      if (ctl() !== EXP_FETCH) begin
        n_fail++;
        $display("FAIL %s fetch[%0d]: ctl=%b expected %b", tag, k, ctl(), EXP_FETCH);
      end
      if (k < waits) tick();
    end
    tick();
    rom_ack = 1'b0;
    instr   = 16'($urandom);
    alu_zr  = zr;
    alu_ng  = ng;
    step    = step_exec;
    #1;
    j     = ref_jump(i, zr, ng) || ref_halt(i, a, pc);
    exp_v = {2'b00, j, !j, 1'b1, 1'b1, 1'b0};
    n_tests++;
    if (ctl() !== exp_v) begin
      n_fail++;
      $display("FAIL %s exec: ctl=%b expected %b", tag, ctl(), exp_v);
    end
    n_tests++;
    if (ir !== i) begin
      n_fail++;
      $display("FAIL %s ir: got %h expected %h", tag, ir, i);
    end
  endtask

  task automatic expect_ctl(input logic [6:0] exp_v, input string tag);
    #1;
    n_tests++;
    if (ctl() !== exp_v) begin
      n_fail++;
      $display("FAIL %s: ctl=%b expected %b", tag, ctl(), exp_v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; rom_ack = 1'b0;
    instr = 16'h0000; alu_zr = 1'b0; alu_ng = 1'b0; a_reg = 16'h0; pc_value = 16'h0;
    for (int c = 0; c < 2; c++) begin
      expect_ctl(EXP_IDLE, "reset_held_ctl");
      n_tests++;
      if (ir !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_held_ir: got %h expected 0000", ir);
      end
      tick();
    end
    reset = 1'b0;
    expect_ctl(EXP_INIT, "init_pc_reset");
    tick();
    for (int c = 0; c < 3; c++) begin
      expect_ctl(EXP_IDLE, "idle_after_init");
      n_tests++;
      if (ir !== 16'h0000) begin
        n_fail++;
        $display("FAIL idle_ir: got %h expected 0000", ir);
      end
      tick();
    end
  endtask

  task automatic test_zero_wait();
    run = 1'b1;
    expect_ctl(EXP_IDLE, "zw_idle");
    tick();
    do_instr(16'h0007, 0, 1'b1, 1'b0, 16'h0001, 16'h0002, 1'b0, "zw_a_instr");
    tick();
    run = 1'b0;
    do_instr(16'hEC10, 0, 1'b0, 1'b0, 16'h0001, 16'h0003, 1'b0, "zw_c_instr");
    tick();
    expect_ctl(EXP_IDLE, "zw_back_to_idle");
  endtask

  task automatic test_wait_states();
    run = 1'b1;
    tick();
    run = 1'b0;
    do_instr(16'hE302, 3, 1'b1, 1'b0, 16'h0040, 16'h0010, 1'b0, "ws_jeq_taken");
    tick();
    expect_ctl(EXP_IDLE, "ws_idle1");
    run = 1'b1;
    tick();
    run = 1'b0;
    do_instr(16'hE302, 3, 1'b0, 1'b1, 16'h0040, 16'h0011, 1'b0, "ws_jeq_not_taken");
    tick();
    expect_ctl(EXP_IDLE, "ws_idle2");
  endtask

  task automatic test_random_stream();
    logic [15:0] i, a, pc;
    int          waits;
    run = 1'b1;
    tick();
    for (int n = 0; n < 60; n++) begin
      i = 16'($urandom);
      if (n % 5 == 0) i = i | 16'h8007;
      waits = $urandom_range(0, 3);
      a     = 16'($urandom);
      pc    = a + 16'($urandom_range(1, 500));
      if (n == 59) run = 1'b0;
      do_instr(i, waits, 1'($urandom), 1'($urandom), a, pc, 1'b0, "rnd");
      tick();
    end
    expect_ctl(EXP_IDLE, "rnd_idle");
  endtask

  task automatic test_step();
    run  = 1'b0;
    step = 1'b1;
    expect_ctl(EXP_IDLE, "step_idle");
    tick();
    do_instr(16'h0123, 0, 1'b0, 1'b0, 16'h0005, 16'h0006, 1'b1, "step_first");
    tick();
    rom_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      expect_ctl(EXP_IDLE, "step_held_no_rerun");
      tick();
    end
    rom_ack = 1'b0;
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    do_instr(16'hE301, 2, 1'b0, 1'b0, 16'h0007, 16'h0008, 1'b1, "step_second");
    tick();
    for (int c = 0; c < 3; c++) begin
      expect_ctl(EXP_IDLE, "step_edge_in_exec_discarded");
      tick();
    end
    step = 1'b0;
  endtask

  task automatic test_halt();
    run = 1'b1;
    tick();
    do_instr(16'hEA87, 1, 1'($urandom), 1'($urandom), 16'h0012, 16'h0012, 1'b0, "halt_exec");
    tick();
    rom_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step = 1'(c);
      expect_ctl(EXP_HALT, "halt_sticky");
      tick();
    end
    rom_ack = 1'b0;
    step    = 1'b0;
    run     = 1'b0;
    reset   = 1'b1;
    expect_ctl(EXP_IDLE, "halt_reset_held");
    tick();
    reset = 1'b0;
    expect_ctl(EXP_INIT, "halt_reset_init");
    tick();
    expect_ctl(EXP_IDLE, "halt_reset_idle");
  endtask

  task automatic test_reset_mid_fetch();
    run = 1'b1;
    tick();
    do_instr(16'h1234, 0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, "pre_abort");
    tick();
    run     = 1'b0;
    rom_ack = 1'b0;
    instr   = 16'hBEEF;
    expect_ctl(EXP_FETCH, "abort_wait1");
    tick();
    expect_ctl(EXP_FETCH, "abort_wait2_before_reset");
    reset = 1'b1;
    expect_ctl(EXP_IDLE, "abort_reset_outputs");
    tick();
    reset = 1'b0;
    expect_ctl(EXP_INIT, "abort_init");
    n_tests++;
    if (ir !== 16'h0000) begin
      n_fail++;
      $display("FAIL abort_ir_cleared: got %h expected 0000", ir);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      expect_ctl(EXP_IDLE, "abort_idle");
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_random_stream();
    test_step();
    test_halt();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
